sclk_sweep_ctrl: RTL and testbench
==================================

Name: sclk_sweep_ctrl

Overview:
Sequencer that drives the maxcount input of the board's clock divider so SCLK steps through a programmed frequency sweep. Starting at BASE, maxcount changes by DELTA per step. Each step is held for HOLD SCLK periods. Updates occur only on an SCLK rising edge, so no runt periods reach the PMOD pin. The block sits between the switch/config logic and the divider, replacing the fixed switch-to-maxcount mapping when sweeping.

Parameters:
CNT_W, 17, width of maxcount, BASE and DELTA
STEPS, 8, number of sweep steps per pass (2..256)
HOLD_W, 8, width of HOLD (SCLK periods per step)

Ports:
CLK  in  1  100 MHz system clock, also clocks the divider
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse; begins a sweep when idle
STOP  in  1  one-cycle pulse; aborts the sweep
MODE  in  1  0 = single pass, 1 = continuous loop
BASE  in  CNT_W  first maxcount value
DELTA  in  CNT_W  maxcount decrement per step
HOLD  in  HOLD_W  SCLK periods per step
SCLK  in  1  divider output, same CLK domain, fed back for edge detection
MAXCOUNT  out  CNT_W  value driven to the divider
DIV_EN  out  1  divider enable; the divider holds SCLK low when 0
BUSY  out  1  high in LOAD/RUN
DONE  out  1  one-cycle pulse at the end of a single pass
STEP_IDX  out  8  current step index

Behaviour:
- Reset (RST_N low, async): state IDLE; MAXCOUNT=1, DIV_EN=0, BUSY=0, DONE=0, STEP_IDX=0, hold_cnt=0, sclk_q=0.
- Edge detect: sclk_q registers SCLK every cycle. rise = SCLK & ~sclk_q.
- Config capture: BASE, DELTA, HOLD and MODE are latched on an accepted START. Input changes during a sweep have no effect.
- Clamps: a latched BASE of 0 becomes 1. A latched HOLD of 0 becomes 1.
- States:
  - IDLE: START (without STOP) -> LOAD. Otherwise stay.
  - LOAD (1 cycle): MAXCOUNT <= BASE, STEP_IDX <= 0, hold_cnt <= 0, DIV_EN <= 1 -> RUN.
  - RUN: on each rise, hold_cnt++. When rise occurs with hold_cnt == HOLD-1, hold_cnt <= 0 and a step boundary occurs.
- At a step boundary with STEP_IDX < STEPS-1: STEP_IDX++, MAXCOUNT <= max(MAXCOUNT-DELTA, 1). Saturating: never 0, no wrap.
- At a step boundary with STEP_IDX == STEPS-1:
  - MODE=1: STEP_IDX <= 0, MAXCOUNT <= BASE, stay in RUN.
  - MODE=0: DIV_EN <= 0, DONE pulses 1 cycle, -> IDLE. MAXCOUNT holds its last value.
- Latency: MAXCOUNT updates on the CLK edge after the SCLK rising edge is sampled, i.e. 1 CLK after SCLK rises.
- STOP: from any state, next cycle -> IDLE, DIV_EN=0, no DONE pulse. STOP and START in the same cycle: STOP wins, and no sweep starts.
- START while BUSY: ignored.
- DELTA=0: the sweep holds BASE for STEPS*HOLD periods (legal).
- Reset mid-sweep: immediate return to reset values. DIV_EN drops asynchronously.
- BUSY = (state != IDLE).

Optional Feature:
SWEEP_PINGPONG_EN.
- Defined: in MODE=1, a direction bit flips at each end of the sweep. After STEP_IDX reaches STEPS-1 the sweep counts down: STEP_IDX--, MAXCOUNT += DELTA, saturating at 2^CNT_W-1. At STEP_IDX 0 it turns up again. No jump back to BASE occurs. MODE=0 behaviour is unchanged.
- Undefined: the loop restarts at BASE as specified above, and the direction logic is absent.

Test Plan:
- Reset then idle: RST_N low for 3 CLK -> MAXCOUNT=1, DIV_EN=0, BUSY=0. With no START, still unchanged after 100 CLK.
- Single pass: BASE=10, DELTA=2, HOLD=2, MODE=0, STEPS=4, START with SCLK modelled by a real divider -> MAXCOUNT sequence 10,8,6,4. Each value is held for exactly 2 SCLK rises. Then one DONE pulse, DIV_EN=0, MAXCOUNT stays 4.
- Saturation: BASE=5, DELTA=3, STEPS=4, HOLD=1 -> MAXCOUNT 5,2,1,1. Never 0.
- Loop mode: BASE=6, DELTA=1, HOLD=1, MODE=1, STEPS=3 -> MAXCOUNT 6,5,4,6,5,4… and DONE is never asserted. Then STOP -> IDLE next CLK, DIV_EN=0, no DONE.
- Collision and abort: START+STOP in the same cycle -> stays IDLE. START again mid-sweep -> STEP_IDX unaffected. RST_N low mid-step -> DIV_EN=0 immediately, without waiting for a CLK edge.
- SWEEP_PINGPONG_EN defined, BASE=6, DELTA=1, STEPS=3, HOLD=1, MODE=1 -> MAXCOUNT 6,5,4,5,6,5,4…

Source files
------------

// File: rtl/sclk_sweep_ctrl.sv
// Frequency-sweep sequencer for the SCLK divider: steps MAXCOUNT from BASE by DELTA, HOLD SCLK periods per step.
// Optional build macro SWEEP_PINGPONG_EN: continuous mode bounces between the two sweep ends instead of restarting.
module sclk_sweep_ctrl #(
  parameter int CNT_W  = 17,
  parameter int STEPS  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              STOP,
  input  logic              MODE,
  input  logic [CNT_W-1:0]  BASE,
  input  logic [CNT_W-1:0]  DELTA,
  input  logic [HOLD_W-1:0] HOLD,
  input  logic              SCLK,
  output logic [CNT_W-1:0]  MAXCOUNT,
  output logic              DIV_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic [7:0]        STEP_IDX
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam logic [7:0] LAST = 8'(STEPS - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    maxcount_q, maxcount_d;
  logic [CNT_W-1:0]    base_q, base_d, delta_q, delta_d;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_cnt_q, hold_cnt_d;
  logic [7:0]          step_idx_q, step_idx_d;
  logic                div_en_q, div_en_d, done_q, done_d, mode_q, mode_d, sclk_q;
  logic                rise;
  logic [CNT_W-1:0]    mc_dn;
`ifdef SWEEP_PINGPONG_EN
  logic                dir_q, dir_d;
  logic [CNT_W:0]      mc_sum;
  logic [CNT_W-1:0]    mc_up;
`endif

  assign rise  = SCLK & ~sclk_q;
  // Saturating step down: the divider must never see a maxcount of 0.
  assign mc_dn = (maxcount_q > delta_q) ? maxcount_q - delta_q : CNT_W'(1);
`ifdef SWEEP_PINGPONG_EN
  assign mc_sum = {1'b0, maxcount_q} + {1'b0, delta_q};
  assign mc_up  = mc_sum[CNT_W] ? '1 : mc_sum[CNT_W-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    maxcount_d = maxcount_q;
    base_d     = base_q;
    delta_d    = delta_q;
    hold_d     = hold_q;
    mode_d     = mode_q;
    hold_cnt_d = hold_cnt_q;
    step_idx_d = step_idx_q;
    div_en_d   = div_en_q;
    done_d     = 1'b0;
`ifdef SWEEP_PINGPONG_EN
    dir_d      = dir_q;
`endif
    case (state_q)
      IDLE: if (START && !STOP) begin
        base_d  = (BASE == '0) ? CNT_W'(1) : BASE;
        delta_d = DELTA;
        hold_d  = (HOLD == '0) ? HOLD_W'(1) : HOLD;
        mode_d  = MODE;
        state_d = LOAD;
      end
      LOAD: begin
        maxcount_d = base_q;
        step_idx_d = '0;
        hold_cnt_d = '0;
        div_en_d   = 1'b1;
        state_d    = RUN;
`ifdef SWEEP_PINGPONG_EN
        dir_d      = 1'b0;
`endif
      end
      RUN: if (rise) begin
        if (hold_cnt_q == hold_q - HOLD_W'(1)) begin
          hold_cnt_d = '0;
`ifdef SWEEP_PINGPONG_EN
          if (dir_q) begin
            if (step_idx_q != 8'd0) begin
              step_idx_d = step_idx_q - 8'd1;
              maxcount_d = mc_up;
            end else begin
              dir_d      = 1'b0;
              step_idx_d = step_idx_q + 8'd1;
              maxcount_d = mc_dn;
            end
          end else if (step_idx_q != LAST) begin
            step_idx_d = step_idx_q + 8'd1;
            maxcount_d = mc_dn;
          end else if (mode_q) begin
            dir_d      = 1'b1;
            step_idx_d = step_idx_q - 8'd1;
            maxcount_d = mc_up;
          end else begin
            div_en_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
`else
          if (step_idx_q != LAST) begin
            step_idx_d = step_idx_q + 8'd1;
            maxcount_d = mc_dn;
          end else if (mode_q) begin
            step_idx_d = '0;
            maxcount_d = base_q;
          end else begin
            div_en_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a simultaneous end-of-pass.
    if (STOP) begin
      state_d  = IDLE;
      div_en_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      maxcount_q <= CNT_W'(1);
      base_q     <= CNT_W'(1);
      delta_q    <= '0;
      hold_q     <= HOLD_W'(1);
      mode_q     <= 1'b0;
      hold_cnt_q <= '0;
      step_idx_q <= '0;
      div_en_q   <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      maxcount_q <= maxcount_d;
      base_q     <= base_d;
      delta_q    <= delta_d;
      hold_q     <= hold_d;
      mode_q     <= mode_d;
      hold_cnt_q <= hold_cnt_d;
      step_idx_q <= step_idx_d;
      div_en_q   <= div_en_d;
      done_q     <= done_d;
      sclk_q     <= SCLK;
`ifdef SWEEP_PINGPONG_EN
      dir_q      <= dir_d;
`endif
    end
  end

  assign MAXCOUNT = maxcount_q;
  assign DIV_EN   = div_en_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign STEP_IDX = step_idx_q;
endmodule

// File: tb/tb_sclk_sweep_ctrl.sv
// Bench for sclk_sweep_ctrl: a divider model closes the SCLK loop, a scoreboard checks every step, pass end and abort.
module tb_sclk_sweep_ctrl;
  localparam int CNT_W  = 17;
  localparam int STEPS  = 4;
  localparam int HOLD_W = 8;

  logic              CLK = 1'b0;
  logic              RST_N, START, STOP, MODE, SCLK;
  logic [CNT_W-1:0]  BASE, DELTA, MAXCOUNT;
  logic [HOLD_W-1:0] HOLD;
  logic              DIV_EN, BUSY, DONE;
  logic [7:0]        STEP_IDX;

  sclk_sweep_ctrl #(.CNT_W(CNT_W), .STEPS(STEPS), .HOLD_W(HOLD_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .MODE(MODE),
    .BASE(BASE), .DELTA(DELTA), .HOLD(HOLD), .SCLK(SCLK),
    .MAXCOUNT(MAXCOUNT), .DIV_EN(DIV_EN), .BUSY(BUSY), .DONE(DONE), .STEP_IDX(STEP_IDX)
  );

  always #5 CLK = ~CLK;

  // Divider model: toggles SCLK every MAXCOUNT+1 clocks, held low while disabled.
  int dcnt = 0;
  initial SCLK = 1'b0;
  always @(posedge CLK) begin
    if (!DIV_EN) begin
      dcnt <= 0;
      SCLK <= 1'b0;
    end else if (dcnt >= int'(MAXCOUNT)) begin
      dcnt <= 0;
      SCLK <= ~SCLK;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  // kind: 0 = step entered, 1 = done pulse, 2 = abort to idle
  typedef struct {int kind; int mc; int idx; int hold;} ev_t;
  ev_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int sat(input longint x);
    if (x < 1) return 1;
    if (x > (1 << CNT_W) - 1) return (1 << CNT_W) - 1;
    return int'(x);
  endfunction

  task automatic push(input int kind, input int mc, input int idx, input int hold);
    ev_t e;
    e.kind = kind; e.mc = mc; e.idx = idx; e.hold = hold;
    q.push_back(e);
  endtask

  // Reference: single pass value at step s is max(BASE - s*DELTA, 1).
  task automatic expect_sweep(input int base, input int delta, input int hold, input int mode, input int n);
    int b, h;
    b = (base == 0) ? 1 : base;
    h = (hold == 0) ? 1 : hold;
    if (mode == 0) begin
      for (int s = 0; s < STEPS; s++) push(0, sat(b - s * delta), s, h);
      push(1, sat(b - (STEPS - 1) * delta), 0, h);
    end else begin
`ifdef SWEEP_PINGPONG_EN
      int mc, i, up;
      mc = b; i = 0; up = 0;
      push(0, mc, i, h);
      for (int k = 1; k < n; k++) begin
        if (i == STEPS - 1) up = 1;
        else if (i == 0) up = 0;
        if (up != 0) begin i--; mc = sat(mc + delta); end
        else begin i++; mc = sat(mc - delta); end
        push(0, mc, i, h);
      end
`else
      for (int k = 0; k < n; k++) push(0, sat(b - (k % STEPS) * delta), k % STEPS, h);
`endif
    end
  endtask

  // Monitor: turns output activity into events and matches them against the queue.
  bit p_busy, p_en, p_sclk, p_rise;
  logic [7:0] p_idx;
  int rises;
  always @(negedge CLK) begin
    ev_t e;
    int k;
    bit rs;
    if (!RST_N) begin
      p_busy = 0; p_en = 0; p_sclk = 0; p_rise = 0; p_idx = 0; rises = 0;
    end else begin
      rs = SCLK && !p_sclk;
      k = -1;
      if (DONE) k = 1;
      else if (p_busy && !BUSY) k = 2;
      else if (DIV_EN && !p_en) k = 3;
      else if (DIV_EN && p_en && STEP_IDX != p_idx) k = 0;
      if (k >= 0) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event kind=%0d maxcount=%0d step_idx=%0d", k, MAXCOUNT, STEP_IDX);
        end else begin
          e = q.pop_front();
          chk("event_kind", (k == 3) ? 0 : k, e.kind);
          if (k == 0 || k == 1) begin
            chk("hold_rises", rises, e.hold);
            chk("update_latency", p_rise, 1);
          end
          if (k == 0 || k == 3) begin
            chk("maxcount", MAXCOUNT, e.mc);
            chk("step_idx", STEP_IDX, e.idx);
          end
          if (k == 1) begin
            chk("done_maxcount", MAXCOUNT, e.mc);
            chk("done_div_en", DIV_EN, 0);
            chk("done_busy", BUSY, 0);
          end
          if (k == 2) chk("stop_div_en", DIV_EN, 0);
        end
        rises = 0;
      end else if (rs) begin
        rises++;
      end
      p_sclk = SCLK; p_rise = rs; p_busy = BUSY; p_en = DIV_EN; p_idx = STEP_IDX;
    end
  end

  task automatic wait_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    chk("pending_events", q.size(), 0);
    q.delete();
  endtask

  task automatic start_cfg(input int base, input int delta, input int hold, input int mode);
    @(posedge CLK); #1;
    BASE = CNT_W'(base); DELTA = CNT_W'(delta); HOLD = HOLD_W'(hold); MODE = mode[0];
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic run_sweep(input int base, input int delta, input int hold, input int mode, input int n);
    expect_sweep(base, delta, hold, mode, n);
    start_cfg(base, delta, hold, mode);
    // A second START with scrambled config mid-sweep must change nothing.
    repeat (2) @(posedge CLK);
    #1;
    BASE = CNT_W'($urandom); DELTA = CNT_W'($urandom); HOLD = HOLD_W'($urandom); MODE = ~MODE;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_empty(20000);
    if (mode != 0) begin
      push(2, 0, 0, 0);
      @(posedge CLK); #1;
      STOP = 1'b1;
      @(posedge CLK); #1;
      STOP = 1'b0;
      chk("stop_busy", BUSY, 0);
      chk("stop_div_en_now", DIV_EN, 0);
      wait_empty(10);
    end
    repeat (4) @(posedge CLK);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; MODE = 1'b0;
    BASE = '0; DELTA = '0; HOLD = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_maxcount", MAXCOUNT, 1);
    chk("rst_div_en", DIV_EN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_step_idx", STEP_IDX, 0);
    RST_N = 1'b1;
    repeat (100) @(posedge CLK);
    #1;
    chk("idle_maxcount", MAXCOUNT, 1);
    chk("idle_div_en", DIV_EN, 0);
    chk("idle_busy", BUSY, 0);

    run_sweep(10, 2, 2, 0, 0);
    run_sweep(5, 3, 1, 0, 0);
    run_sweep(0, 0, 0, 0, 0);
    run_sweep(6, 1, 1, 1, 2 * STEPS + 1);
    run_sweep(7, 0, 3, 0, 0);

    // START and STOP together: nothing starts.
    @(posedge CLK); #1;
    BASE = 17'd7; DELTA = 17'd1; HOLD = 8'd1; MODE = 1'b0;
    START = 1'b1; STOP = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; STOP = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("collide_busy", BUSY, 0);
    chk("collide_div_en", DIV_EN, 0);

    // Reset in the middle of a step.
    push(0, 10, 0, 3);
    start_cfg(10, 1, 3, 1);
    wait_empty(200);
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk("async_rst_div_en", DIV_EN, 0);
    chk("async_rst_maxcount", MAXCOUNT, 1);
    chk("async_rst_busy", BUSY, 0);
    chk("async_rst_step_idx", STEP_IDX, 0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (3) @(posedge CLK);

    for (int t = 0; t < 12; t++) begin
      int b, d, h, m;
      b = $urandom_range(0, 20);
      d = $urandom_range(0, 7);
      h = $urandom_range(0, 4);
      m = $urandom_range(0, 1);
      run_sweep(b, d, h, m, (m != 0) ? $urandom_range(STEPS, 3 * STEPS) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
